sdram_slot_arbiter: RTL and testbench

Shares the single-port 8-bit SDRAM controller between three requesters: PPU reads, CPU reads/writes, and loader writes (ROM download / save restore). Runs on the SDRAM clock `clk`. Grants at most one access per SDRAM slot, where a slot is one `clkref` period (16 `clk` cycles). Drives the controller's `addr`/`we`/`din`/`oeA`/`oeB` and returns read data with a per-requester ack. Guarantees refresh slots and prevents loader starvation.

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_arb_pick.sv | 39 +++
 rtl/sdram_slot_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_sdram_slot_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM slot arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_arb_pkg;

    localparam int SDRAM_ADDR_W = 25;
    // clk cycles per clkref period, i.e. per SDRAM slot
    localparam int SLOT_CLKS    = 16;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PPU  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_LD   = 2'd3
    } gnt_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Priority picker choosing the owner of the next SDRAM slot.
// Latency: purely combinational.
// Backpressure: none; the requester that just completed is masked for one slot.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic ppu_req_i,
    input  logic cpu_req_i,
    input  logic ld_req_i,
    input  gnt_t done_gnt_i,
    input  logic force_idle_i,
    input  logic ld_promote_i,
    output gnt_t next_gnt_o
);

    logic ppu_ok;
    logic cpu_ok;
    logic ld_ok;

    // Refresh idle first, then a starved loader, then PPU > CPU > LD.
    always_comb begin
        ppu_ok     = ppu_req_i && (done_gnt_i != GNT_PPU);
        cpu_ok     = cpu_req_i && (done_gnt_i != GNT_CPU);
        ld_ok      = ld_req_i  && (done_gnt_i != GNT_LD);
        next_gnt_o = GNT_NONE;
        if (force_idle_i) begin
            next_gnt_o = GNT_NONE;
        end else if (ld_promote_i && ld_ok) begin
            next_gnt_o = GNT_LD;
        end else if (ppu_ok) begin
            next_gnt_o = GNT_PPU;
        end else if (cpu_ok) begin
            next_gnt_o = GNT_CPU;
        end else if (ld_ok) begin
            next_gnt_o = GNT_LD;
        end
    end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Shares one 8-bit SDRAM controller between PPU reads, CPU reads/writes and loader writes, one access per clkref slot.
// Latency: a request seen on a clkref rising edge is granted on that edge and acked on the next edge (one slot).
// Backpressure: requests are level-held until their ack pulse; forced refresh idles and loader promotion bound the wait.
module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W        = SDRAM_ADDR_W,
    parameter int REFRESH_SLOTS = 8,
    parameter int LD_MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clkref,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    output logic              ppu_ack,
    output logic [7:0]        ppu_dout,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic [7:0]        cpu_dout,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_din,
    output logic              ld_ack,
    output logic [ADDR_W-1:0] sd_addr,
    output logic              sd_we,
    output logic [7:0]        sd_din,
    output logic              sd_oeA,
    output logic              sd_oeB,
    input  logic [7:0]        sd_doutA,
    input  logic [7:0]        sd_doutB
);

    // Both limits are at most 255, so 8-bit counters suffice.
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(REFRESH_SLOTS);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(LD_MAX_WAIT);

    logic              clkref_q;
    gnt_t              gnt_q,      gnt_d;
    logic [CNT_W-1:0]  run_cnt_q,  run_cnt_d;
    logic [CNT_W-1:0]  ld_wait_q,  ld_wait_d;
    logic              ppu_ack_q,  ppu_ack_d;
    logic              cpu_ack_q,  cpu_ack_d;
    logic              ld_ack_q,   ld_ack_d;
    logic [7:0]        ppu_dout_q, ppu_dout_d;
    logic [7:0]        cpu_dout_q, cpu_dout_d;
    logic [ADDR_W-1:0] sd_addr_q,  sd_addr_d;
    logic [7:0]        sd_din_q,   sd_din_d;
    logic              sd_we_q,    sd_we_d;
    logic              sd_oeA_q,   sd_oeA_d;
    logic              sd_oeB_q,   sd_oeB_d;

    logic slot_edge;
    logic force_idle;
    logic ld_promote;
    gnt_t pick_gnt;

    assign slot_edge  = clkref & ~clkref_q;
    assign force_idle = (run_cnt_q == RUN_MAX);
    assign ld_promote = ld_req && (ld_wait_q == WAIT_MAX);

    sdram_arb_pick u_pick (
        .ppu_req_i    (ppu_req),
        .cpu_req_i    (cpu_req),
        .ld_req_i     (ld_req),
        .done_gnt_i   (gnt_q),
        .force_idle_i (force_idle),
        .ld_promote_i (ld_promote),
        .next_gnt_o   (pick_gnt)
    );

    // On a slot edge: retire the current owner, grant the next one and latch its request.
    always_comb begin
        gnt_d      = gnt_q;
        run_cnt_d  = run_cnt_q;
        ld_wait_d  = ld_wait_q;
        ppu_ack_d  = 1'b0;
        cpu_ack_d  = 1'b0;
        ld_ack_d   = 1'b0;
        ppu_dout_d = ppu_dout_q;
        cpu_dout_d = cpu_dout_q;
        sd_addr_d  = sd_addr_q;
        sd_din_d   = sd_din_q;
        sd_we_d    = sd_we_q;
        sd_oeA_d   = sd_oeA_q;
        sd_oeB_d   = sd_oeB_q;
        if (slot_edge) begin
            case (gnt_q)
                GNT_PPU: begin
                    ppu_ack_d  = 1'b1;
                    ppu_dout_d = sd_doutB;
                end
                GNT_CPU: begin
                    cpu_ack_d = 1'b1;
                    // sd_oeA marks the finishing CPU slot as a read
                    if (sd_oeA_q) begin
                        cpu_dout_d = sd_doutA;
                    end
                end
                GNT_LD:  ld_ack_d = 1'b1;
                default: ;
            endcase

            gnt_d    = pick_gnt;
            sd_we_d  = 1'b0;
            sd_oeA_d = 1'b0;
            sd_oeB_d = 1'b0;
            case (pick_gnt)
                GNT_PPU: begin
                    sd_oeB_d  = 1'b1;
                    sd_addr_d = ppu_addr;
                end
                GNT_CPU: begin
                    sd_addr_d = cpu_addr;
                    if (cpu_we) begin
                        sd_we_d  = 1'b1;
                        sd_din_d = cpu_din;
                    end else begin
                        sd_oeA_d = 1'b1;
                    end
                end
                GNT_LD: begin
                    sd_we_d   = 1'b1;
                    sd_addr_d = ld_addr;
                    sd_din_d  = ld_din;
                end
                default: ;
            endcase

            if (pick_gnt == GNT_NONE) begin
                run_cnt_d = '0;
            end else if (run_cnt_q != RUN_MAX) begin
                run_cnt_d = run_cnt_q + 1'b1;
            end

            if (!ld_req || (pick_gnt == GNT_LD)) begin
                ld_wait_d = '0;
            end else if (ld_wait_q != WAIT_MAX) begin
                ld_wait_d = ld_wait_q + 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any in-flight slot without an ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            clkref_q   <= 1'b0;
            gnt_q      <= GNT_NONE;
            run_cnt_q  <= '0;
            ld_wait_q  <= '0;
            ppu_ack_q  <= 1'b0;
            cpu_ack_q  <= 1'b0;
            ld_ack_q   <= 1'b0;
            ppu_dout_q <= '0;
            cpu_dout_q <= '0;
            sd_addr_q  <= '0;
            sd_din_q   <= '0;
            sd_we_q    <= 1'b0;
            sd_oeA_q   <= 1'b0;
            sd_oeB_q   <= 1'b0;
        end else begin
            clkref_q   <= clkref;
            gnt_q      <= gnt_d;
            run_cnt_q  <= run_cnt_d;
            ld_wait_q  <= ld_wait_d;
            ppu_ack_q  <= ppu_ack_d;
            cpu_ack_q  <= cpu_ack_d;
            ld_ack_q   <= ld_ack_d;
            ppu_dout_q <= ppu_dout_d;
            cpu_dout_q <= cpu_dout_d;
            sd_addr_q  <= sd_addr_d;
            sd_din_q   <= sd_din_d;
            sd_we_q    <= sd_we_d;
            sd_oeA_q   <= sd_oeA_d;
            sd_oeB_q   <= sd_oeB_d;
        end
    end

    assign ppu_ack  = ppu_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign ld_ack   = ld_ack_q;
    assign ppu_dout = ppu_dout_q;
    assign cpu_dout = cpu_dout_q;
    assign sd_addr  = sd_addr_q;
    assign sd_din   = sd_din_q;
    assign sd_we    = sd_we_q;
    assign sd_oeA   = sd_oeA_q;
    assign sd_oeB   = sd_oeB_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: directed scenarios plus randomized traffic against a slot-level model.
// Latency: n/a.
// Backpressure: requesters hold their level request until the ack pulse.
module tb_sdram_slot_arbiter;
    import sdram_arb_pkg::*;

    localparam int AW      = SDRAM_ADDR_W;
    localparam int REFRESH = 8;
    localparam int LDMAX   = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clkref = 1'b0;
    logic          ppu_req = 1'b0;
    logic [AW-1:0] ppu_addr = '0;
    logic          ppu_ack;
    logic [7:0]    ppu_dout;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_din = '0;
    logic          cpu_ack;
    logic [7:0]    cpu_dout;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [7:0]    ld_din = '0;
    logic          ld_ack;
    logic [AW-1:0] sd_addr;
    logic          sd_we;
    logic [7:0]    sd_din;
    logic          sd_oeA;
    logic          sd_oeB;
    logic [7:0]    sd_doutA = '0;
    logic [7:0]    sd_doutB = '0;

    int n_checks = 0;
    int n_pass   = 0;

    sdram_slot_arbiter #(
        .ADDR_W(AW), .REFRESH_SLOTS(REFRESH), .LD_MAX_WAIT(LDMAX)
    ) dut (
        .clk(clk), .reset(reset), .clkref(clkref),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_dout(ppu_dout),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
        .sd_addr(sd_addr), .sd_we(sd_we), .sd_din(sd_din), .sd_oeA(sd_oeA), .sd_oeB(sd_oeB),
        .sd_doutA(sd_doutA), .sd_doutB(sd_doutB)
    );

    always #5 clk = ~clk;

    // clkref: 8 high / 8 low clk cycles; stall freezes it at its current level
    int phase = 0;
    bit stall = 1'b0;
    initial forever begin
        @(negedge clk);
        if (!stall) phase = (phase + 1) % SLOT_CLKS;
        clkref = (phase < SLOT_CLKS / 2);
    end

    // Slot-level reference model: owner codes 0 none, 1 ppu, 2 cpu, 3 ld
    int            m_gnt = 0;
    bit            m_wr = 1'b0;
    int            m_run = 0;
    int            m_wait = 0;
    bit            m_cq = 1'b0;
    bit            m_edge = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_din = '0;
    logic [7:0]    m_pdout = '0;
    logic [7:0]    m_cdout = '0;
    bit            m_pack = 1'b0;
    bit            m_cack = 1'b0;
    bit            m_lack = 1'b0;

    always @(posedge clk) begin
        bit want [4];
        int nxt;
        if (reset) begin
            m_gnt = 0; m_wr = 0; m_run = 0; m_wait = 0; m_cq = 0; m_edge = 0;
            m_addr = '0; m_din = '0; m_pdout = '0; m_cdout = '0;
            m_pack = 0; m_cack = 0; m_lack = 0;
        end else begin
            m_edge = clkref && !m_cq;
            m_cq   = clkref;
            m_pack = 0; m_cack = 0; m_lack = 0;
            if (m_edge) begin
                if (m_gnt == 1) begin m_pack = 1; m_pdout = sd_doutB; end
                if (m_gnt == 2) begin m_cack = 1; if (!m_wr) m_cdout = sd_doutA; end
                if (m_gnt == 3) m_lack = 1;
                want[0] = 0; want[1] = ppu_req; want[2] = cpu_req; want[3] = ld_req;
                want[m_gnt] = 0;
                nxt = 0;
                if (m_run >= REFRESH) nxt = 0;
                else if (want[3] && m_wait >= LDMAX) nxt = 3;
                else for (int k = 1; k <= 3; k++) if (nxt == 0 && want[k]) nxt = k;
                m_run  = (nxt == 0) ? 0 : ((m_run < REFRESH) ? m_run + 1 : m_run);
                m_wait = (ld_req && nxt != 3) ? ((m_wait < LDMAX) ? m_wait + 1 : m_wait) : 0;
                if (nxt == 1) m_addr = ppu_addr;
                if (nxt == 2) begin m_addr = cpu_addr; m_wr = cpu_we; if (cpu_we) m_din = cpu_din; end
                if (nxt == 3) begin m_addr = ld_addr; m_din = ld_din; end
                m_gnt = nxt;
            end
        end
    end

    // Decodes the current slot owner from the controller-side outputs.
    function automatic int code_of();
        if (!(sd_we || sd_oeA || sd_oeB)) return 0;
        if (sd_oeB) return 1;
        if (sd_oeA) return 2;
        return (sd_addr == ld_addr) ? 3 : 2;
    endfunction

    // Waits until the negedge following a slot edge; ok=0 if none within 40 cycles.
    task automatic next_edge(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_edge) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        bit ok;
        @(negedge clk);
        reset = 1'b1; ppu_req = 0; cpu_req = 0; ld_req = 0; cpu_we = 0; stall = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        next_edge(ok);
        if (!ok) begin n_checks++; $display("FAIL reset_sync: no slot edge within 40 cycles"); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; ppu_req = 1; cpu_req = 1; ld_req = 1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({sd_we, sd_oeA, sd_oeB, ppu_ack, cpu_ack, ld_ack} !== 6'b0 || sd_addr !== '0 ||
            sd_din !== 8'h00 || ppu_dout !== 8'h00 || cpu_dout !== 8'h00)
            $display("FAIL reset_state: ctl=%b%b%b ack=%b%b%b addr=%h din=%h pdout=%h cdout=%h, want all zero",
                     sd_we, sd_oeA, sd_oeB, ppu_ack, cpu_ack, ld_ack, sd_addr, sd_din, ppu_dout, cpu_dout);
        else n_pass++;
        // a slot edge during reset must not grant anything
        repeat (SLOT_CLKS + 2) @(negedge clk);
        n_checks++;
        if ({sd_we, sd_oeA, sd_oeB, ppu_ack, cpu_ack, ld_ack} !== 6'b0)
            $display("FAIL reset_hold: ctl/ack=%b, want 000000", {sd_we, sd_oeA, sd_oeB, ppu_ack, cpu_ack, ld_ack});
        else n_pass++;
        ppu_req = 0; cpu_req = 0; ld_req = 0;
        reset = 1'b0;
    endtask

    task automatic test_ppu_read();
        bit ok;
        int cyc;
        do_reset();
        sd_doutB = 8'hA5; sd_doutA = 8'h11; ppu_addr = 25'h0000123; ppu_req = 1;
        next_edge(ok);
        n_checks++;
        if (!ok || sd_oeB !== 1'b1 || sd_oeA !== 1'b0 || sd_we !== 1'b0 || sd_addr !== 25'h0000123)
            $display("FAIL ppu_grant: ok=%b oeB=%b oeA=%b we=%b addr=%h, want oeB=1 oeA=0 we=0 addr=0000123",
                     ok, sd_oeB, sd_oeA, sd_we, sd_addr);
        else n_pass++;
        cyc = 0;
        while (!ppu_ack && cyc < 40) begin @(negedge clk); cyc++; end
        ppu_req = 0;
        n_checks++;
        if (ppu_ack !== 1'b1 || cyc != SLOT_CLKS || ppu_dout !== 8'hA5 || sd_oeB !== 1'b0)
            $display("FAIL ppu_ack: ack=%b after %0d cycles dout=%h oeB=%b, want ack=1 after 16 dout=a5 oeB=0",
                     ppu_ack, cyc, ppu_dout, sd_oeB);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ppu_ack !== 1'b0 || ppu_dout !== 8'hA5)
            $display("FAIL ppu_ack_pulse: ack=%b dout=%h, want ack=0 dout=a5", ppu_ack, ppu_dout);
        else n_pass++;
    endtask

    task automatic test_contention();
        bit ok;
        int         exp_g [4] = '{1, 2, 3, 0};
        logic [2:0] exp_a [4] = '{3'b000, 3'b100, 3'b010, 3'b001};
        do_reset();
        ppu_addr = 25'h00000A1; cpu_addr = 25'h00000B2; ld_addr = 25'h00000C3; ld_din = 8'h5E;
        cpu_we = 0; ppu_req = 1; cpu_req = 1; ld_req = 1;
        for (int s = 0; s < 4; s++) begin
            next_edge(ok);
            n_checks++;
            if (!ok || code_of() != exp_g[s] || {ppu_ack, cpu_ack, ld_ack} !== exp_a[s] ||
                (exp_g[s] == 3 && sd_din !== 8'h5E))
                $display("FAIL contention slot%0d: owner=%0d acks=%b din=%h, want owner=%0d acks=%b",
                         s, code_of(), {ppu_ack, cpu_ack, ld_ack}, sd_din, exp_g[s], exp_a[s]);
            else n_pass++;
            if (ppu_ack) ppu_req = 0;
            if (cpu_ack) cpu_req = 0;
            if (ld_ack)  ld_req = 0;
        end
    endtask

    task automatic test_cpu_write();
        bit ok;
        int cyc;
        int bad;
        do_reset();
        sd_doutA = 8'h77; cpu_we = 1; cpu_addr = 25'h01E0005; cpu_din = 8'h3C; cpu_req = 1;
        next_edge(ok);
        bad = ok ? 0 : 1;
        for (cyc = 0; cyc < 40 && !cpu_ack; cyc++) begin
            if (cyc == 5) cpu_din = 8'hFF;
            if (cyc == 6) cpu_addr = 25'h0000000;
            if (sd_we !== 1'b1 || sd_din !== 8'h3C || sd_addr !== 25'h01E0005 || sd_oeA || sd_oeB) bad++;
            @(negedge clk);
        end
        cpu_req = 0; cpu_we = 0;
        n_checks++;
        if (bad != 0)
            $display("FAIL cpu_write_hold: %0d bad cycles (last we=%b din=%h addr=%h), want we=1 din=3c addr=01e0005",
                     bad, sd_we, sd_din, sd_addr);
        else n_pass++;
        n_checks++;
        if (cpu_ack !== 1'b1 || cyc != SLOT_CLKS || cpu_dout !== 8'h00)
            $display("FAIL cpu_write_ack: ack=%b after %0d cycles dout=%h, want ack=1 after 16 dout=00",
                     cpu_ack, cyc, cpu_dout);
        else n_pass++;
    endtask

    task automatic test_starvation();
        bit ok;
        int n;
        bit got;
        do_reset();
        ppu_addr = 25'h0000001; cpu_addr = 25'h0000002; ld_addr = 25'h00ABCDE; ld_din = 8'h42;
        cpu_we = 0; ppu_req = 1; cpu_req = 1; ld_req = 1;
        n = 0; got = 0; ok = 1;
        while (!got && ok && n < 8) begin
            next_edge(ok);
            n++;
            if (code_of() == 3) got = 1;
        end
        ppu_req = 0; cpu_req = 0; ld_req = 0;
        n_checks++;
        if (!got || n > LDMAX + 1)
            $display("FAIL ld_starvation: ld granted=%b at edge %0d, want granted by edge %0d", got, n, LDMAX + 1);
        else n_pass++;
    endtask

    task automatic test_refresh();
        bit ok;
        bit granted;
        do_reset();
        ppu_addr = 25'h0000011; cpu_addr = 25'h0000022; ld_addr = 25'h0000033;
        cpu_we = 0; ppu_req = 1; cpu_req = 1; ld_req = 1;
        for (int s = 1; s <= REFRESH + 2; s++) begin
            next_edge(ok);
            granted = sd_we | sd_oeA | sd_oeB;
            n_checks++;
            if (!ok || granted !== (s != REFRESH + 1))
                $display("FAIL refresh slot%0d: granted=%b, want %b", s, granted, (s != REFRESH + 1));
            else n_pass++;
        end
        ppu_req = 0; cpu_req = 0; ld_req = 0;
    endtask

    task automatic test_reset_mid_slot();
        bit ok;
        bit seen;
        int cyc;
        do_reset();
        sd_doutA = 8'h5A; cpu_we = 0; cpu_addr = 25'h0000777; cpu_req = 1;
        next_edge(ok);
        n_checks++;
        if (!ok || sd_oeA !== 1'b1 || sd_addr !== 25'h0000777)
            $display("FAIL rst_mid_grant: oeA=%b addr=%h, want oeA=1 addr=0000777", sd_oeA, sd_addr);
        else n_pass++;
        repeat (5) @(negedge clk);
        reset = 1'b1; cpu_req = 0;
        @(negedge clk);
        n_checks++;
        if ({sd_we, sd_oeA, sd_oeB, ppu_ack, cpu_ack, ld_ack} !== 6'b0 || sd_addr !== '0 || cpu_dout !== 8'h00)
            $display("FAIL rst_mid_clear: ctl/ack=%b addr=%h cdout=%h, want all zero",
                     {sd_we, sd_oeA, sd_oeB, ppu_ack, cpu_ack, ld_ack}, sd_addr, cpu_dout);
        else n_pass++;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 2 * SLOT_CLKS; i++) begin @(negedge clk); if (cpu_ack) seen = 1; end
        n_checks++;
        if (seen) $display("FAIL rst_mid_noack: cpu_ack=1 after abandoned slot, want 0");
        else n_pass++;
        cpu_req = 1;
        next_edge(ok);
        cyc = 0;
        while (!cpu_ack && cyc < 40) begin @(negedge clk); cyc++; end
        cpu_req = 0;
        n_checks++;
        if (!ok || cpu_ack !== 1'b1 || cpu_dout !== 8'h5A)
            $display("FAIL rst_mid_rerequest: ack=%b dout=%h, want ack=1 dout=5a", cpu_ack, cpu_dout);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        bit seen;
        bit held;
        int cyc;
        do_reset();
        ppu_addr = 25'h0000456; sd_doutB = 8'hC7; ppu_req = 1;
        next_edge(ok);
        stall = 1'b1;
        seen = 0; held = ok;
        repeat (3 * SLOT_CLKS) begin
            @(negedge clk);
            if (ppu_ack) seen = 1;
            if (sd_oeB !== 1'b1 || sd_addr !== 25'h0000456) held = 0;
        end
        n_checks++;
        if (seen || !held)
            $display("FAIL stall_hold: ack_seen=%b held=%b, want ack_seen=0 held=1", seen, held);
        else n_pass++;
        stall = 1'b0;
        cyc = 0;
        while (!ppu_ack && cyc < 40) begin @(negedge clk); cyc++; end
        ppu_req = 0;
        n_checks++;
        if (ppu_ack !== 1'b1 || ppu_dout !== 8'hC7)
            $display("FAIL stall_resume: ack=%b dout=%h, want ack=1 dout=c7", ppu_ack, ppu_dout);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [54:0] got_v;
        logic [54:0] exp_v;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            got_v = {sd_we, sd_oeA, sd_oeB, sd_addr, sd_din, ppu_ack, cpu_ack, ld_ack, ppu_dout, cpu_dout};
            exp_v = {(m_gnt == 3) || (m_gnt == 2 && m_wr), (m_gnt == 2 && !m_wr), (m_gnt == 1),
                     m_addr, m_din, m_pack, m_cack, m_lack, m_pdout, m_cdout};
            n_checks++;
            if (got_v !== exp_v)
                $display("FAIL random cycle %0d: we/oeA/oeB/addr/din/acks/pdout/cdout got %h want %h", c, got_v, exp_v);
            else n_pass++;
            reset    = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 63) == 0) stall = ~stall;
            sd_doutA = 8'($urandom);
            sd_doutB = 8'($urandom);
            ppu_addr = AW'($urandom);
            cpu_addr = AW'($urandom);
            ld_addr  = AW'($urandom);
            cpu_din  = 8'($urandom);
            ld_din   = 8'($urandom);
            cpu_we   = 1'($urandom_range(0, 1));
            if (ppu_ack) ppu_req = 1'($urandom_range(0, 1));
            else if (!ppu_req) ppu_req = ($urandom_range(0, 5) == 0);
            if (cpu_ack) cpu_req = 1'($urandom_range(0, 1));
            else if (!cpu_req) cpu_req = ($urandom_range(0, 5) == 0);
            if (ld_ack) ld_req = 1'($urandom_range(0, 1));
            else if (!ld_req) ld_req = ($urandom_range(0, 5) == 0);
        end
        reset = 1'b0; stall = 1'b0;
        ppu_req = 0; cpu_req = 0; ld_req = 0;
    endtask

    initial begin
        test_reset();
        test_ppu_read();
        test_contention();
        test_cpu_write();
        test_starvation();
        test_refresh();
        test_reset_mid_slot();
        test_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
